// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of a streaming FFT pipeline.
//   Buffers upstream samples and issues whole frames of FFT_SIZE samples to
//   the first pipeline stage. When no further frame is ready, it follows with
//   a zero-filled flush frame that drains the reorder buffers. A small tag FIFO
//   records whether each issued frame is real or flush. The output side uses
//   these tags to pass real bins and drop flush bins.
//
// Parameters:
//   FFT_SIZE        points per frame (power of two, >= 4)
//   NUM_FRAMES_BUF  sample buffer depth in whole frames (>= 2)
//   DATA_W          width of one complex sample, packed as {re, im}
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   s_data/s_valid/s_ready        upstream sample stream
//   pipe_din/pipe_din_valid       to first FFT stage (registered)
//   pipe_dout/pipe_dout_valid     from last FFT stage
//   m_data/m_valid/m_first/m_last/m_index   output bins (registered)
//   busy                          sequencer active or frames still in flight
//   err                           sticky tag FIFO error
//
// Build option: define FFT_FRAME_CTRL_BITREV_EN to report m_index as the
// bit-reversed out counter (natural bin number). Otherwise m_index is the
// raw out counter.

module fft_frame_ctrl #(
  parameter int FFT_SIZE       = 16,
  parameter int NUM_FRAMES_BUF = 2,
  parameter int DATA_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_W-1:0]           pipe_din,
  output logic                        pipe_din_valid,
  input  logic [DATA_W-1:0]           pipe_dout,
  input  logic                        pipe_dout_valid,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  output logic                        m_first,
  output logic                        m_last,
  output logic [$clog2(FFT_SIZE)-1:0] m_index,
  output logic                        busy,
  output logic                        err
);

  localparam int DEPTH = NUM_FRAMES_BUF * FFT_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(FFT_SIZE);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FFT_SIZE);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FFT_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t        r_state, w_state_next;
  logic [BW-1:0] r_beat, w_beat_next;

  // ---------------- sample FIFO ----------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, w_count_next;
  logic              r_rdy_en;   // keeps s_ready low while reset is applied
  logic              w_push, w_pop;

  assign s_ready      = r_rdy_en & (r_count != FULL_CNT);
  assign w_push       = s_valid & s_ready;
  assign w_pop        = (r_state == ST_RUN);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rdy_en       <= 1'b0;
      pipe_din       <= '0;
      pipe_din_valid <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      r_count        <= w_count_next;
      // Flush beats carry zeros but stay valid so the pipeline keeps moving.
      pipe_din_valid <= (r_state != ST_IDLE);
      pipe_din       <= w_pop ? r_mem[r_rd_ptr] : '0;
    end
  end

  // ---------------- frame sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (r_count >= FRAME_CNT) begin
          w_state_next = ST_RUN;
          w_beat_next  = '0;
        end
      end
      ST_RUN: begin
        if (r_beat == LAST_BEAT) begin
          w_beat_next  = '0;
          // Occupancy after this beat's pop decides back-to-back vs flush.
          w_state_next = (w_count_next >= FRAME_CNT) ? ST_RUN : ST_FLUSH;
        end else begin
          w_beat_next = r_beat + BW'(1);
        end
      end
      ST_FLUSH: begin
        // A frame that fills up mid-flush waits here until the last beat.
        if (r_beat == LAST_BEAT) begin
          w_beat_next  = '0;
          w_state_next = (r_count >= FRAME_CNT) ? ST_RUN : ST_IDLE;
        end else begin
          w_beat_next = r_beat + BW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_beat_next  = '0;
      end
    endcase
  end

  // ---------------- tag FIFO (1 = real frame, 0 = flush frame) ----------------
  logic          r_tag_mem [4];
  logic [1:0]    r_tag_wr, r_tag_rd;
  logic [2:0]    r_tag_cnt;
  logic [BW-1:0] r_out_cnt;
  logic          w_tag_push, w_tag_full, w_tag_empty, w_tag_pop, w_tag_wr_en;
  logic          w_out_last, w_head, w_real;
  logic [BW-1:0] w_index;

  assign w_tag_push  = (r_state != ST_IDLE) & (r_beat == '0);
  assign w_tag_full  = (r_tag_cnt == 3'd4);
  assign w_tag_empty = (r_tag_cnt == 3'd0);
  assign w_out_last  = (r_out_cnt == LAST_BEAT);
  assign w_tag_pop   = pipe_dout_valid & w_out_last & ~w_tag_empty;
  assign w_tag_wr_en = w_tag_push & ~w_tag_full;
  assign w_head      = r_tag_mem[r_tag_rd];
  // Output beats with no matching tag are never passed downstream.
  assign w_real      = pipe_dout_valid & ~w_tag_empty & w_head;

  always_ff @(posedge clk) begin
    if (w_tag_wr_en) r_tag_mem[r_tag_wr] <= (r_state == ST_RUN);
  end

`ifdef FFT_FRAME_CTRL_BITREV_EN
  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_bitrev
      assign w_index[gi] = r_out_cnt[BW-1-gi];
    end
  endgenerate
`else
  assign w_index = r_out_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
      r_tag_cnt <= '0;
      r_out_cnt <= '0;
      err       <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
      m_index   <= '0;
    end else begin
      if (w_tag_wr_en) r_tag_wr <= r_tag_wr + 2'd1;
      if (w_tag_pop)   r_tag_rd <= r_tag_rd + 2'd1;
      r_tag_cnt <= r_tag_cnt + 3'(w_tag_wr_en) - 3'(w_tag_pop);
      // Counter holds across gaps in pipe_dout_valid; wraps naturally at FFT_SIZE.
      if (pipe_dout_valid) r_out_cnt <= r_out_cnt + BW'(1);
      if ((w_tag_push & w_tag_full) | (pipe_dout_valid & w_tag_empty)) err <= 1'b1;
      m_data  <= pipe_dout;
      m_valid <= w_real;
      m_first <= w_real & (r_out_cnt == '0);
      m_last  <= w_real & w_out_last;
      m_index <= w_index;
    end
  end

  assign busy = (r_state != ST_IDLE) | ~w_tag_empty;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;
  localparam int N   = 16;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] pipe_din;
  logic          pipe_din_valid;
  logic [DW-1:0] pipe_dout;
  logic          pipe_dout_valid;
  logic [DW-1:0] m_data;
  logic          m_valid, m_first, m_last;
  logic [3:0]    m_index;
  logic          busy, err;
  logic          inj_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.FFT_SIZE(N), .NUM_FRAMES_BUF(2), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pipe_din(pipe_din), .pipe_din_valid(pipe_din_valid),
    .pipe_dout(pipe_dout), .pipe_dout_valid(pipe_dout_valid),
    .m_data(m_data), .m_valid(m_valid), .m_first(m_first), .m_last(m_last),
    .m_index(m_index), .busy(busy), .err(err)
  );

  // Stand-in FFT pipeline: fixed-latency pass-through, not reset.
  logic [DW-1:0]  pl_d [LAT] = '{default: '0};
  logic [LAT-1:0] pl_v = '0;
  always @(posedge clk) begin
    pl_d[0] <= pipe_din;
    pl_v[0] <= pipe_din_valid;
    for (int i = 1; i < LAT; i++) begin
      pl_d[i] <= pl_d[i-1];
      pl_v[i] <= pl_v[i-1];
    end
  end
  assign pipe_dout       = inj_valid ? 32'h5A5A_5A5A : pl_d[LAT-1];
  assign pipe_dout_valid = pl_v[LAT-1] | inj_valid;

  // Passive monitor: logs and counters only ever increase.
  int            din_n = 0, seg_n = 0, mv_n = 0, mf_n = 0, ml_n = 0;
  logic          prev_v = 1'b0;
  logic [DW-1:0] din_log  [1024];
  logic [DW-1:0] mdat_log [1024];
  logic [3:0]    midx_log [1024];
  always @(negedge clk) begin
    if (pipe_din_valid && !prev_v) seg_n++;
    prev_v = pipe_din_valid;
    if (pipe_din_valid) begin din_log[din_n % 1024] = pipe_din; din_n++; end
    if (m_valid) begin
      mdat_log[mv_n % 1024] = m_data;
      midx_log[mv_n % 1024] = m_index;
      mv_n++;
    end
    if (m_first) mf_n++;
    if (m_last)  ml_n++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; inj_valid = 1'b0; rst = 1'b1;
    repeat (8) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_burst(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      s_data = base + DW'(i); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    repeat (4) tick();
    k = 0;
    while ((busy || pipe_din_valid) && k < 400) begin tick(); k++; end
    repeat (3) tick();
    total++;
    if (k >= 400) begin bad++; $display("FAIL %s idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, k); end
  endtask

  task automatic wait_din_valid(input string name);
    int k = 0;
    while (!pipe_din_valid && k < 60) begin tick(); k++; end
    total++;
    if (k >= 60) begin bad++; $display("FAIL %s start_timeout: pipe_din_valid=0, required 1", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %0b need 0", s_ready); end
    total++; if ({pipe_din_valid, m_valid, m_first, m_last, err, busy} !== 6'b0) begin bad++;
      $display("FAIL rst_flags: got %b need 000000", {pipe_din_valid, m_valid, m_first, m_last, err, busy}); end
    total++; if ({pipe_din, m_data, m_index} !== '0) begin bad++;
      $display("FAIL rst_data: pipe_din=%h m_data=%h m_index=%0d need 0", pipe_din, m_data, m_index); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready: got %0b need 1", s_ready); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rel_idle: busy=%0b err=%0b need 0 0", busy, err); end
    $display("test_reset: done");
  endtask

  task automatic test_single_frame();
    int bd, bm, bf, bl, bs, e;
    do_reset();
    bd = din_n; bm = mv_n; bf = mf_n; bl = ml_n; bs = seg_n;
    push_burst(N, 32'hA000_0000);
    wait_idle("single");
    total++; if (din_n - bd != 2*N) begin bad++; $display("FAIL single_din_beats: got %0d need %0d", din_n - bd, 2*N); end
    total++; if (seg_n - bs != 1) begin bad++; $display("FAIL single_din_segments: got %0d need 1", seg_n - bs); end
    e = 0;
    for (int i = 0; i < 2*N; i++)
      if (din_log[(bd+i)%1024] !== ((i < N) ? 32'hA000_0000 + DW'(i) : 32'h0)) e++;
    total++; if (e != 0) begin bad++; $display("FAIL single_din_data: %0d wrong beats, need 0", e); end
    total++; if (mv_n - bm != N) begin bad++; $display("FAIL single_m_beats: got %0d need %0d", mv_n - bm, N); end
    total++; if (mf_n - bf != 1 || ml_n - bl != 1) begin bad++;
      $display("FAIL single_first_last: first=%0d last=%0d need 1 1", mf_n - bf, ml_n - bl); end
    e = 0;
    for (int i = 0; i < N; i++)
      if (mdat_log[(bm+i)%1024] !== 32'hA000_0000 + DW'(i) || midx_log[(bm+i)%1024] !== 4'(i)) e++;
    total++; if (e != 0) begin bad++; $display("FAIL single_m_data_index: %0d wrong beats, need 0", e); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %0b need 0", err); end
    $display("test_single_frame: din=%0d m=%0d", din_n - bd, mv_n - bm);
  endtask

  task automatic test_back_to_back();
    int bd, bm, bf, bl, bs, e;
    do_reset();
    bd = din_n; bm = mv_n; bf = mf_n; bl = ml_n; bs = seg_n;
    push_burst(3*N, 32'hB000_0000);
    wait_idle("b2b");
    total++; if (din_n - bd != 4*N) begin bad++; $display("FAIL b2b_din_beats: got %0d need %0d", din_n - bd, 4*N); end
    total++; if (seg_n - bs != 1) begin bad++; $display("FAIL b2b_din_segments: got %0d need 1", seg_n - bs); end
    e = 0;
    for (int i = 0; i < 4*N; i++)
      if (din_log[(bd+i)%1024] !== ((i < 3*N) ? 32'hB000_0000 + DW'(i) : 32'h0)) e++;
    total++; if (e != 0) begin bad++; $display("FAIL b2b_din_data: %0d wrong beats, need 0", e); end
    total++; if (mv_n - bm != 3*N) begin bad++; $display("FAIL b2b_m_beats: got %0d need %0d", mv_n - bm, 3*N); end
    total++; if (mf_n - bf != 3 || ml_n - bl != 3) begin bad++;
      $display("FAIL b2b_first_last: first=%0d last=%0d need 3 3", mf_n - bf, ml_n - bl); end
    e = 0;
    for (int i = 0; i < 3*N; i++)
      if (mdat_log[(bm+i)%1024] !== 32'hB000_0000 + DW'(i) || midx_log[(bm+i)%1024] !== 4'(i % N)) e++;
    total++; if (e != 0) begin bad++; $display("FAIL b2b_m_data_index: %0d wrong beats, need 0", e); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %0b need 0", err); end
    $display("test_back_to_back: din=%0d m=%0d", din_n - bd, mv_n - bm);
  endtask

  task automatic test_flush_wait();
    int bd, bm, bf, bl, bs, e;
    logic [DW-1:0] exp_v;
    do_reset();
    bd = din_n; bm = mv_n; bf = mf_n; bl = ml_n; bs = seg_n;
    push_burst(N, 32'hD000_0000);
    wait_din_valid("flushwait");
    // Now at RUN beat 1; second frame's last sample lands in FLUSH beat 5.
    repeat (4) tick();
    push_burst(N, 32'hD100_0000);
    wait_idle("flushwait");
    total++; if (din_n - bd != 4*N) begin bad++; $display("FAIL flushwait_din_beats: got %0d need %0d", din_n - bd, 4*N); end
    total++; if (seg_n - bs != 1) begin bad++; $display("FAIL flushwait_din_segments: got %0d need 1", seg_n - bs); end
    e = 0;
    for (int i = 0; i < 4*N; i++) begin
      if (i < N)          exp_v = 32'hD000_0000 + DW'(i);
      else if (i < 2*N)   exp_v = 32'h0;
      else if (i < 3*N)   exp_v = 32'hD100_0000 + DW'(i - 2*N);
      else                exp_v = 32'h0;
      if (din_log[(bd+i)%1024] !== exp_v) e++;
    end
    total++; if (e != 0) begin bad++; $display("FAIL flushwait_din_order: %0d wrong beats, need 0", e); end
    total++; if (mv_n - bm != 2*N || mf_n - bf != 2 || ml_n - bl != 2) begin bad++;
      $display("FAIL flushwait_m: beats=%0d first=%0d last=%0d need %0d 2 2", mv_n - bm, mf_n - bf, ml_n - bl, 2*N); end
    $display("test_flush_wait: din=%0d m=%0d", din_n - bd, mv_n - bm);
  endtask

  task automatic test_full();
    int acc = 0;
    do_reset();
    force dut.w_pop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s_data = 32'hC000_0000 + DW'(i); s_valid = 1'b1;
      if (s_ready) acc++;
      tick();
    end
    total++; if (acc != 32) begin bad++; $display("FAIL full_accepted: got %0d need 32", acc); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready: got %0b need 0", s_ready); end
    s_valid = 1'b0;
    release dut.w_pop;
    do_reset();
    $display("test_full: accepted=%0d", acc);
  endtask

  task automatic test_err();
    int bm;
    do_reset();
    bm = mv_n;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre: got %0b need 0", err); end
    inj_valid = 1'b1;
    repeat (3) tick();
    inj_valid = 1'b0;
    repeat (2) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0b need 1", err); end
    repeat (10) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b need 1", err); end
    total++; if (mv_n - bm != 0) begin bad++; $display("FAIL err_m_valid: got %0d beats need 0", mv_n - bm); end
    $display("test_err: err=%0b", err);
  endtask

  task automatic test_reset_midframe();
    int bd, bm;
    do_reset();
    push_burst(N, 32'hE000_0000);
    wait_din_valid("midrst");
    repeat (6) tick();   // RUN beat 7
    rst = 1'b1;
    #1;
    total++; if ({pipe_din_valid, m_valid, m_first, m_last, err, busy, s_ready} !== 7'b0) begin bad++;
      $display("FAIL midrst_flags: got %b need 0000000", {pipe_din_valid, m_valid, m_first, m_last, err, busy, s_ready}); end
    total++; if ({pipe_din, m_data, m_index} !== '0) begin bad++;
      $display("FAIL midrst_data: pipe_din=%h m_data=%h m_index=%0d need 0", pipe_din, m_data, m_index); end
    tick();
    rst = 1'b0;
    bd = din_n; bm = mv_n;
    repeat (40) tick();
    total++; if (din_n - bd != 0) begin bad++; $display("FAIL midrst_fifo_empty: din beats %0d need 0", din_n - bd); end
    total++; if (s_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL midrst_idle: s_ready=%0b busy=%0b need 1 0", s_ready, busy); end
    total++; if (err !== 1'b1 || mv_n - bm != 0) begin bad++;
      $display("FAIL midrst_inflight: err=%0b m beats=%0d need 1 0", err, mv_n - bm); end
    $display("test_reset_midframe: err=%0b", err);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_flush_wait();
    test_full();
    test_err();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
